// File: rtl/uart_pkg.sv
// Shared type definitions for the UART transmit path.
// Holds the arbiter FSM states next to the transmitter's own state type.
package uart_pkg;

  typedef enum logic {
    IDLE,
    XFER
  } arb_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

endpackage

// File: rtl/axis_uart_tx_arbiter_rr_pick.sv
// Rotating-priority selector.
// Returns the first asserted request at or after ptr, wrapping modulo N.
module rr_pick #(
  parameter int N = 4,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] idx,
  output logic         found
);

  // Scan downward so the candidate closest to ptr is the last one written.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N]) begin
        idx   = W'((int'(ptr) + k) % N);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axis_uart_tx_arbiter.sv
// Round-robin AXI4-Stream arbiter in front of a UART transmitter.
// A grant is held for a whole message, or until the per-grant beat limit is reached.
module axis_uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_SRC     = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int MAX_PKT_LEN = 64
) (
  input  logic                          clk,
  input  logic                          rst_sync,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] s_tdata,
  input  logic [NUM_SRC-1:0]            s_tvalid,
  input  logic [NUM_SRC-1:0]            s_tlast,
  output logic [NUM_SRC-1:0]            s_tready,
  output logic [DATA_WIDTH-1:0]         m_tdata,
  output logic                          m_tvalid,
  input  logic                          m_tready,
  output logic [$clog2(NUM_SRC)-1:0]    m_tid,
  output logic                          busy,
  output logic                          pkt_done,
  output logic                          pkt_trunc
);

  localparam int ID_W  = $clog2(NUM_SRC);
  localparam int CNT_W = $clog2(MAX_PKT_LEN + 1);

  arb_state_t       state, state_nxt;
  logic [ID_W-1:0]  grant, grant_nxt;
  logic [ID_W-1:0]  rr_ptr, rr_ptr_nxt;
  logic [CNT_W-1:0] beat_cnt, beat_cnt_nxt;
  logic             pkt_done_nxt, pkt_trunc_nxt;
  logic [ID_W-1:0]  pick_idx;
  logic             pick_found;
  logic             accept;

  rr_pick #(
    .N (NUM_SRC),
    .W (ID_W)
  ) u_rr_pick (
    .req   (s_tvalid),
    .ptr   (rr_ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );

  always_ff @(posedge clk) begin
    if (rst_sync) begin
      state     <= IDLE;
      grant     <= '0;
      rr_ptr    <= '0;
      beat_cnt  <= '0;
      pkt_done  <= 1'b0;
      pkt_trunc <= 1'b0;
    end else begin
      state     <= state_nxt;
      grant     <= grant_nxt;
      rr_ptr    <= rr_ptr_nxt;
      beat_cnt  <= beat_cnt_nxt;
      pkt_done  <= pkt_done_nxt;
      pkt_trunc <= pkt_trunc_nxt;
    end
  end

  // Handshake outputs are masked while reset is high so nothing moves mid-reset.
  always_comb begin
    state_nxt     = state;
    grant_nxt     = grant;
    rr_ptr_nxt    = rr_ptr;
    beat_cnt_nxt  = beat_cnt;
    pkt_done_nxt  = 1'b0;
    pkt_trunc_nxt = 1'b0;
    accept        = 1'b0;
    s_tready      = '0;
    m_tvalid      = 1'b0;
    m_tdata       = s_tdata[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
    m_tid         = rst_sync ? '0 : grant;

    unique case (state)
      IDLE: begin
        if (pick_found) begin
          state_nxt    = XFER;
          grant_nxt    = pick_idx;
          beat_cnt_nxt = '0;
        end
      end
      XFER: begin
        if (!rst_sync) begin
          m_tvalid        = s_tvalid[grant];
          s_tready[grant] = m_tready;
          accept          = s_tvalid[grant] & m_tready;
        end
        if (accept) begin
          beat_cnt_nxt = beat_cnt + 1'b1;
          // tlast wins when it lands on the limit beat
          if (s_tlast[grant] || (beat_cnt == CNT_W'(MAX_PKT_LEN - 1))) begin
            state_nxt     = IDLE;
            rr_ptr_nxt    = (grant == ID_W'(NUM_SRC - 1)) ? '0 : grant + 1'b1;
            pkt_done_nxt  = s_tlast[grant];
            pkt_trunc_nxt = ~s_tlast[grant];
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == XFER);

endmodule

// File: tb/tb_axis_uart_tx_arbiter.sv
// Bench for axis_uart_tx_arbiter: fixed vector table, directed corner sequences,
// and randomized traffic compared against a message-level reference model.
module tb_axis_uart_tx_arbiter;

  localparam int NS   = 4;
  localparam int DW   = 8;
  localparam int MAXL = 4;

  logic             clk = 1'b0;
  logic             rst_sync;
  logic [NS*DW-1:0] s_tdata;
  logic [NS-1:0]    s_tvalid;
  logic [NS-1:0]    s_tlast;
  logic [NS-1:0]    s_tready;
  logic [DW-1:0]    m_tdata;
  logic             m_tvalid;
  logic             m_tready;
  logic [1:0]       m_tid;
  logic             busy;
  logic             pkt_done;
  logic             pkt_trunc;

  always #5 clk = ~clk;

  axis_uart_tx_arbiter #(
    .NUM_SRC     (NS),
    .DATA_WIDTH  (DW),
    .MAX_PKT_LEN (MAXL)
  ) dut (
    .clk       (clk),
    .rst_sync  (rst_sync),
    .s_tdata   (s_tdata),
    .s_tvalid  (s_tvalid),
    .s_tlast   (s_tlast),
    .s_tready  (s_tready),
    .m_tdata   (m_tdata),
    .m_tvalid  (m_tvalid),
    .m_tready  (m_tready),
    .m_tid     (m_tid),
    .busy      (busy),
    .pkt_done  (pkt_done),
    .pkt_trunc (pkt_trunc)
  );

  typedef struct {
    logic          rst;
    logic [NS-1:0] vld;
    logic [NS-1:0] lst;
    logic [NS*DW-1:0] dat;
    logic          mrdy;
    logic          evld;
    logic [1:0]    etid;
    logic [DW-1:0] edat;
    logic [NS-1:0] erdy;
    logic          ebusy;
    logic          edone;
    logic          etrunc;
  } vec_t;

  typedef struct {
    logic [DW-1:0] d;
    logic          l;
  } beat_t;

  vec_t  tbl[$];
  beat_t srcQ[NS][$];

  // Reference model: who owns the UART, how many beats it has sent, where the next search starts.
  int   mOwner;
  int   mGrantId;
  int   mPtr;
  int   mBeats;
  logic mDone;
  logic mTrunc;

  logic [NS-1:0] gate = '1;
  logic mrdyReq = 1'b1;
  logic rstReq  = 1'b0;

  int total = 0;
  int bad = 0;
  int cycleNo = 0;
  int dutTids[$];
  int doneCnt = 0;
  int truncCnt = 0;
  int acceptCnt = 0;
  int pushedCnt = 0;

  function automatic vec_t mk(logic rst, logic [NS-1:0] vld, logic [NS-1:0] lst,
                              logic [NS*DW-1:0] dat, logic mrdy, logic evld,
                              logic [1:0] etid, logic [DW-1:0] edat, logic [NS-1:0] erdy,
                              logic ebusy, logic edone, logic etrunc);
    vec_t v;
    v.rst = rst; v.vld = vld; v.lst = lst; v.dat = dat; v.mrdy = mrdy;
    v.evld = evld; v.etid = etid; v.edat = edat; v.erdy = erdy;
    v.ebusy = ebusy; v.edone = edone; v.etrunc = etrunc;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s cycle=%0d got=0x%0h exp=0x%0h", name, cycleNo, got, exp);
    end
  endtask

  task automatic modelReset();
    mOwner = -1; mGrantId = 0; mPtr = 0; mBeats = 0; mDone = 1'b0; mTrunc = 1'b0;
  endtask

  function automatic bit pending();
    for (int i = 0; i < NS; i++) if (srcQ[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic pushMsg(input int src, input int len, input logic [DW-1:0] base);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      b.d = base + DW'(k);
      b.l = (k == len - 1);
      srcQ[src].push_back(b);
      pushedCnt++;
    end
  endtask

  task automatic applyStimulus();
    rst_sync = rstReq;
    m_tready = mrdyReq;
    for (int i = 0; i < NS; i++) begin
      if (srcQ[i].size() > 0 && gate[i]) begin
        s_tvalid[i] = 1'b1;
        s_tdata[i*DW +: DW] = srcQ[i][0].d;
        s_tlast[i] = srcQ[i][0].l;
      end else begin
        s_tvalid[i] = 1'b0;
        s_tdata[i*DW +: DW] = '0;
        s_tlast[i] = 1'b0;
      end
    end
  endtask

  task automatic checkOutput(output logic acc);
    logic          expVld;
    logic [NS-1:0] expRdy;
    expVld = 1'b0;
    expRdy = '0;
    if (!rst_sync && mOwner >= 0) begin
      expVld = s_tvalid[mOwner];
      expRdy[mOwner] = m_tready;
    end
    check("m_tvalid", 32'(m_tvalid), 32'(expVld));
    check("s_tready", 32'(s_tready), 32'(expRdy));
    check("m_tid", 32'(m_tid), rst_sync ? 32'd0 : 32'(mGrantId));
    check("busy", 32'(busy), 32'(mOwner >= 0));
    check("pkt_done", 32'(pkt_done), 32'(mDone));
    check("pkt_trunc", 32'(pkt_trunc), 32'(mTrunc));
    if (expVld) check("m_tdata", 32'(m_tdata), 32'(srcQ[mOwner][0].d));
    acc = expVld && m_tready;
  endtask

  // One clock of the model-checked flow: drive, compare, clock, advance the model.
  task automatic cycle();
    logic          acc;
    logic          rstNow;
    logic          lastNow;
    logic [NS-1:0] vldNow;
    logic          found;
    beat_t         tmp;
    applyStimulus();
    #1;
    checkOutput(acc);
    if (m_tvalid && m_tready) begin
      dutTids.push_back(int'(m_tid));
      acceptCnt++;
    end
    doneCnt  += int'(pkt_done);
    truncCnt += int'(pkt_trunc);
    rstNow  = rst_sync;
    vldNow  = s_tvalid;
    lastNow = acc ? srcQ[mOwner][0].l : 1'b0;
    @(posedge clk);
    cycleNo++;
    if (rstNow) begin
      modelReset();
    end else if (mOwner < 0) begin
      mDone = 1'b0; mTrunc = 1'b0; found = 1'b0;
      for (int k = 0; k < NS; k++) begin
        if (!found && vldNow[(mPtr + k) % NS]) begin
          found = 1'b1;
          mOwner = (mPtr + k) % NS;
          mGrantId = mOwner;
          mBeats = 0;
        end
      end
    end else begin
      mDone = 1'b0; mTrunc = 1'b0;
      if (acc) begin
        tmp = srcQ[mOwner].pop_front();
        mBeats++;
        if (lastNow || mBeats == MAXL) begin
          mDone  = lastNow;
          mTrunc = !lastNow;
          mPtr   = (mOwner + 1) % NS;
          mOwner = -1;
        end
      end
    end
    #1;
  endtask

  task automatic doReset();
    rstReq = 1'b1;
    cycle();
    rstReq = 1'b0;
    dutTids.delete();
    doneCnt = 0;
    truncCnt = 0;
  endtask

  task automatic runUntilEmpty(input int budget, input bit randomize);
    int n = 0;
    while ((pending() || mOwner >= 0) && n < budget) begin
      if (randomize) begin
        for (int i = 0; i < NS; i++) gate[i] = ($urandom_range(0, 4) != 0);
        mrdyReq = ($urandom_range(0, 3) != 0);
      end
      cycle();
      n++;
    end
    check("drain_timeout", 32'(pending() || mOwner >= 0), 32'd0);
    gate = '1;
    mrdyReq = 1'b1;
    cycle();
    cycle();
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog cycle=%0d got=hang exp=finish", cycleNo);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int a0;
    int expOrder[8] = '{0, 0, 1, 1, 2, 2, 3, 3};

    rst_sync = 1'b1; s_tvalid = '0; s_tlast = '0; s_tdata = '0; m_tready = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Single source (src1: 41,42,43 with one stall), then the src3 -> src0 wrap.
    tbl.push_back(mk(1'b1, 4'b0000, 4'b0000, 32'h0000_0000, 1'b1, 1'b0, 2'd0, 8'h00, 4'b0000, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 4'b0000, 4'b0000, 32'h0000_0000, 1'b1, 1'b0, 2'd0, 8'h00, 4'b0000, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 4'b0010, 4'b0000, 32'h0000_4100, 1'b1, 1'b0, 2'd0, 8'h00, 4'b0000, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 4'b0010, 4'b0000, 32'h0000_4100, 1'b1, 1'b1, 2'd1, 8'h41, 4'b0010, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 4'b0010, 4'b0000, 32'h0000_4200, 1'b0, 1'b1, 2'd1, 8'h42, 4'b0000, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 4'b0010, 4'b0000, 32'h0000_4200, 1'b1, 1'b1, 2'd1, 8'h42, 4'b0010, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 4'b0010, 4'b0010, 32'h0000_4300, 1'b1, 1'b1, 2'd1, 8'h43, 4'b0010, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 4'b0000, 4'b0000, 32'h0000_0000, 1'b1, 1'b0, 2'd1, 8'h00, 4'b0000, 1'b0, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 4'b1000, 4'b1000, 32'h3300_0000, 1'b1, 1'b0, 2'd1, 8'h00, 4'b0000, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 4'b1000, 4'b1000, 32'h3300_0000, 1'b1, 1'b1, 2'd3, 8'h33, 4'b1000, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 4'b1001, 4'b1001, 32'h3B00_000A, 1'b1, 1'b0, 2'd3, 8'h00, 4'b0000, 1'b0, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 4'b1001, 4'b1001, 32'h3B00_000A, 1'b1, 1'b1, 2'd0, 8'h0A, 4'b0001, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 4'b0000, 4'b0000, 32'h0000_0000, 1'b1, 1'b0, 2'd0, 8'h00, 4'b0000, 1'b0, 1'b1, 1'b0));

    for (int r = 0; r < tbl.size(); r++) begin
      rst_sync = tbl[r].rst; s_tvalid = tbl[r].vld; s_tlast = tbl[r].lst;
      s_tdata = tbl[r].dat; m_tready = tbl[r].mrdy;
      #1;
      check($sformatf("row%0d_m_tvalid", r), 32'(m_tvalid), 32'(tbl[r].evld));
      check($sformatf("row%0d_m_tid", r), 32'(m_tid), 32'(tbl[r].etid));
      check($sformatf("row%0d_s_tready", r), 32'(s_tready), 32'(tbl[r].erdy));
      check($sformatf("row%0d_busy", r), 32'(busy), 32'(tbl[r].ebusy));
      check($sformatf("row%0d_pkt_done", r), 32'(pkt_done), 32'(tbl[r].edone));
      check($sformatf("row%0d_pkt_trunc", r), 32'(pkt_trunc), 32'(tbl[r].etrunc));
      if (tbl[r].evld) check($sformatf("row%0d_m_tdata", r), 32'(m_tdata), 32'(tbl[r].edat));
      @(posedge clk);
      cycleNo++;
      #1;
    end

    modelReset();

    // Contention: four 2-beat messages, expected to be served 0,1,2,3 without interleaving.
    doReset();
    for (int i = 0; i < NS; i++) pushMsg(i, 2, DW'(8'h10 * (i + 1)));
    runUntilEmpty(200, 1'b0);
    check("contention_beats", 32'(dutTids.size()), 32'd8);
    for (int i = 0; i < 8; i++)
      if (i < dutTids.size()) check($sformatf("contention_tid%0d", i), 32'(dutTids[i]), 32'(expOrder[i]));
    check("contention_done", 32'(doneCnt), 32'd4);

    // Beat limit: src2 sends 6 beats, truncated after 4, the rest ends with tlast.
    doReset();
    pushMsg(2, 6, 8'h60);
    runUntilEmpty(200, 1'b0);
    check("limit_beats", 32'(dutTids.size()), 32'd6);
    check("limit_trunc", 32'(truncCnt), 32'd1);
    check("limit_done", 32'(doneCnt), 32'd1);

    // tlast on exactly the limit beat reports done only.
    doReset();
    pushMsg(0, MAXL, 8'h70);
    runUntilEmpty(200, 1'b0);
    check("coincide_done", 32'(doneCnt), 32'd1);
    check("coincide_trunc", 32'(truncCnt), 32'd0);

    // Backpressure: UART stalls 20 cycles after the first beat of src1.
    doReset();
    pushMsg(1, 3, 8'hB1);
    n = 0;
    while (srcQ[1].size() > 2 && n < 20) begin cycle(); n++; end
    check("bp_first_beat", 32'(srcQ[1].size()), 32'd2);
    mrdyReq = 1'b0;
    a0 = acceptCnt;
    repeat (20) cycle();
    check("bp_stalled_accepts", 32'(acceptCnt - a0), 32'd0);
    mrdyReq = 1'b1;
    runUntilEmpty(200, 1'b0);
    check("bp_beats", 32'(dutTids.size()), 32'd3);

    // Reset after beat 2 of 5 on src3; src1 then wins from a cleared pointer.
    doReset();
    pushMsg(3, 5, 8'hC1);
    n = 0;
    while (srcQ[3].size() > 3 && n < 20) begin cycle(); n++; end
    check("rst_mid_beats_before", 32'(srcQ[3].size()), 32'd3);
    pushMsg(1, 2, 8'hD1);
    doReset();
    runUntilEmpty(200, 1'b0);
    check("rst_mid_first_tid", dutTids.size() > 0 ? 32'(dutTids[0]) : 32'hFFFF_FFFF, 32'd1);
    check("rst_mid_done", 32'(doneCnt), 32'd2);

    // Randomized traffic with valid gaps and UART backpressure.
    doReset();
    for (int m = 0; m < 40; m++)
      pushMsg($urandom_range(0, NS - 1), $urandom_range(1, 6), DW'($urandom));
    runUntilEmpty(5000, 1'b1);
    check("scoreboard_beats", 32'(acceptCnt), 32'(pushedCnt));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
